// File: rtl/i2c_sclgen.sv
// I2C master SCL generator: sequences low/high phases against an external divider,
// with byte-level hold, slave clock stretching and multi-master clock synchronisation.
module i2c_sclgen (
  input  logic       clk,
  input  logic       rst_an,
  input  logic       run,
  input  logic       hold,
  input  logic       zero,
  input  logic       scl_in,
  output logic [1:0] load,
  output logic       scl_oe,
  output logic       scl_rise,
  output logic       scl_fall,
  output logic       stretch,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, LOW_LD, LOW, HOLD, STRETCH, HIGH_LD, HIGH
  } state_t;

  state_t     state, stNext;
  logic [1:0] sclSync;
  logic       sclS;
  logic       firstCyc;

  assign sclS = sclSync[1];

  // Idle-high synchroniser so a released bus never looks like a low pulse out of reset.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) sclSync <= 2'b11;
    else         sclSync <= {sclSync[0], scl_in};
  end

  always_comb begin
    stNext = state;
    case (state)
      IDLE:    if (run) stNext = LOW_LD;
      LOW_LD:  stNext = LOW;
      LOW:     if (!firstCyc && zero) stNext = hold ? HOLD : STRETCH;
      HOLD:    if (!hold) stNext = STRETCH;
      STRETCH: if (sclS) stNext = HIGH_LD;
      HIGH_LD: stNext = HIGH;
      // Another master pulling SCL low ends our high phase early, regardless of the divider.
      HIGH: begin
        if (!firstCyc) begin
          if (!sclS)     stNext = LOW_LD;
          else if (zero) stNext = run ? LOW_LD : IDLE;
        end
      end
      default: stNext = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state    <= IDLE;
      firstCyc <= 1'b0;
      load     <= 2'b00;
      scl_oe   <= 1'b0;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      stretch  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= stNext;
      firstCyc <= (stNext != state);
      load     <= {stNext == HIGH_LD, stNext == LOW_LD};
      scl_oe   <= (stNext == LOW_LD) || (stNext == LOW) || (stNext == HOLD);
      scl_rise <= (stNext == HIGH_LD);
      scl_fall <= (stNext == LOW_LD);
      stretch  <= (stNext == STRETCH);
      busy     <= (stNext != IDLE);
    end
  end

endmodule

// File: tb/tb_i2c_sclgen.sv
// Directed self-checking bench for i2c_sclgen with a small reloadable divider model.
module tb_i2c_sclgen;

  logic       clk = 1'b0;
  logic       rst_an = 1'b0;
  logic       run = 1'b0, hold = 1'b0, sclIn = 1'b1;
  logic       zero;
  logic [1:0] zeroCtl = 2'd1;   // 0: divider model, 1: forced 1, 2: forced 0
  logic [3:0] divCnt;
  logic [1:0] load;
  logic       scl_oe, scl_rise, scl_fall, stretch, busy;
  int         nCmp = 0, nErr = 0;

  i2c_sclgen dut (
    .clk(clk), .rst_an(rst_an), .run(run), .hold(hold), .zero(zero), .scl_in(sclIn),
    .load(load), .scl_oe(scl_oe), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .stretch(stretch), .busy(busy)
  );

  always #5 clk = ~clk;

  // Divider reloads to 3 on any load strobe, so zero returns four cycles after the load cycle.
  always @(posedge clk or negedge rst_an) begin
    if (!rst_an)           divCnt <= 4'd0;
    else if (load != 2'b00) divCnt <= 4'd3;
    else if (divCnt != 0)  divCnt <= divCnt - 4'd1;
  end
  assign zero = (zeroCtl == 2'd0) ? (divCnt == 4'd0) : (zeroCtl == 2'd1);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Per-cycle check of scl_oe and load; pattern MSB corresponds to the first cycle.
  task automatic seqChk(input string tag, input int n, input logic [31:0] oePat,
                        input logic [63:0] ldPat);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s oe[%0d]", tag, i), scl_oe, oePat[n-1-i]);
      chk($sformatf("%s load[%0d]", tag, i), load, ldPat[2*(n-1-i) +: 2]);
    end
  endtask

  task automatic doReset();
    rst_an = 1'b0; run = 1'b0; hold = 1'b0; sclIn = 1'b1; zeroCtl = 2'd1;
    tick(2);
    chk("reset outs", {load, scl_oe, scl_rise, scl_fall, stretch, busy}, 7'b0);
    rst_an = 1'b1;
    tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Zero held high: 3-cycle low phase, STRETCH + 3-cycle high phase.
    doReset();
    chk("idle after reset", busy, 1'b0);
    run = 1'b1;
    seqChk("zero1", 14, 32'b11100001110000, 64'b0100000010000001000000100000);
    @(negedge clk);
    chk("fall pulse", {scl_fall, load}, 3'b101);
    run = 1'b0;  // dropped during the low phase; both phases must still finish
    seqChk("rundrop", 8, 32'b11000000, 64'b0000001000000000);
    chk("idle busy", busy, 1'b0);
    chk("idle oe", scl_oe, 1'b0);

    // Divider model: 5-cycle low, STRETCH + 5-cycle high.
    doReset();
    zeroCtl = 2'd0;
    run = 1'b1;
    seqChk("div", 12, 32'b111110000001, 64'b010000000000100000000001);

    // Slave stretch: scl_in low for 10 cycles starting in the low phase.
    doReset();
    run = 1'b1;
    tick(1);
    chk("first fall", scl_fall, 1'b1);
    sclIn = 1'b0;
    tick(2);
    for (int i = 4; i <= 13; i++) begin
      @(negedge clk);
      chk($sformatf("stretch[%0d]", i), {stretch, scl_oe, load}, 4'b1000);
      if (i == 11) sclIn = 1'b1;
    end
    @(negedge clk);
    chk("post-stretch", {stretch, scl_rise, load}, 4'b0110);

    // Clock synchronisation: another master pulls SCL low during our high phase.
    doReset();
    run = 1'b1;
    tick(5);
    chk("in HIGH_LD", {scl_rise, load}, 3'b110);
    zeroCtl = 2'd2;
    tick(3);
    chk("high wait", {load, scl_oe, busy}, 4'b0001);
    sclIn = 1'b0;
    tick(1);
    chk("sync +1", scl_oe, 1'b0);
    tick(1);
    chk("sync +2", scl_oe, 1'b0);
    tick(1);
    chk("sync +3", {load, scl_oe, scl_fall}, 4'b0111);
    sclIn = 1'b1;

    // Byte-level hold keeps SCL low until released.
    doReset();
    hold = 1'b1;
    run = 1'b1;
    tick(4);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("hold[%0d]", i), {load, scl_oe, stretch}, 4'b0010);
    end
    hold = 1'b0;
    @(negedge clk);
    chk("hold->stretch", {stretch, scl_oe}, 2'b10);
    @(negedge clk);
    chk("hold->high_ld", {scl_rise, load}, 3'b110);

    // Asynchronous reset during the low phase.
    doReset();
    run = 1'b1;
    tick(2);
    chk("pre-abort oe", scl_oe, 1'b1);
    #2 rst_an = 1'b0;
    #1 chk("async abort", {load, scl_oe, busy}, 4'b0000);
    @(negedge clk);
    run = 1'b0;
    rst_an = 1'b1;
    tick(4);
    chk("stay idle", {busy, scl_oe}, 2'b00);
    run = 1'b1;
    tick(1);
    chk("restart", {scl_fall, load, busy}, 4'b1011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
